// File: rtl/gt_link_ctrl.sv
// gt_link_ctrl: multi-lane transceiver bring-up sequencer (QPLL, TX/RX resets, comma alignment, retries).
// Define GT_LINK_POL_AUTO_EN to flip RX polarity of misaligned lanes on each alignment retry.
`timescale 1ns/1ps
module gt_link_ctrl #(
  parameter int NUM_CH = 4,
  parameter int RST_HOLD_CYC = 16,
  parameter int TIMEOUT_CYC = 1000000,
  parameter int STABLE_CYC = 1024,
  parameter int MAX_RETRY = 3,
  parameter logic [NUM_CH-1:0] RX_POL_INIT = {NUM_CH{1'b0}}
) (
  input  logic              i_sysclk,
  input  logic              i_rst_n,
  input  logic              i_enable,
  input  logic              i_qplllock,
  input  logic [NUM_CH-1:0] i_tx_done,
  input  logic [NUM_CH-1:0] i_rx_done,
  input  logic [NUM_CH-1:0] i_rx_ByteAlign,
  output logic [NUM_CH-1:0] o_tx_rst,
  output logic [NUM_CH-1:0] o_rx_rst,
  output logic [NUM_CH-1:0] o_rx_polarity,
  output logic [NUM_CH-1:0] o_ch_up,
  output logic              o_link_up,
  output logic              o_fail,
  output logic [3:0]        o_retry_cnt,
  output logic [3:0]        o_state
);
  localparam int SW = $clog2(STABLE_CYC + 1);
  typedef enum logic [3:0] {
    IDLE = 4'd0, WAIT_QPLL = 4'd1, TX_RST = 4'd2, TX_WAIT = 4'd3, RX_RST = 4'd4,
    RX_WAIT = 4'd5, ALIGN = 4'd6, UP = 4'd7, FAIL = 4'd8
  } state_t;
  state_t state, state_n;
  logic [1:0] qpll_sy;
  logic [1:0][NUM_CH-1:0] tx_sy, rx_sy, al_sy;
  logic [31:0] tmo_cnt;
  logic [SW-1:0] stb_cnt;
  logic [3:0] retry_cnt;
  logic qpll_s, all_tx, all_rx, all_al, tmo, hold_done, stb_full, can_retry;
  logic tmo_hit, retry_inc, retry_clr, restart;
  assign qpll_s = qpll_sy[1];
  assign all_tx = &tx_sy[1];
  assign all_rx = &rx_sy[1];
  assign all_al = &al_sy[1];
  assign tmo = tmo_cnt == 32'(TIMEOUT_CYC - 1);
  assign hold_done = tmo_cnt == 32'(RST_HOLD_CYC - 1);
  assign stb_full = stb_cnt == SW'(STABLE_CYC - 1);
  assign can_retry = retry_cnt < 4'(MAX_RETRY);
  always_comb begin
    state_n = state;
    tmo_hit = 1'b0;
    case (state)
      IDLE:      state_n = WAIT_QPLL;
      WAIT_QPLL: if (qpll_s) state_n = TX_RST; else tmo_hit = tmo;
      TX_RST:    if (hold_done) state_n = TX_WAIT;
      TX_WAIT:   if (all_tx) state_n = RX_RST; else tmo_hit = tmo;
      RX_RST:    if (hold_done) state_n = RX_WAIT;
      RX_WAIT:   if (all_rx) state_n = ALIGN; else tmo_hit = tmo;
      ALIGN:     if (all_al && stb_full) state_n = UP; else tmo_hit = tmo;
      UP:        if (!qpll_s) state_n = WAIT_QPLL; else if (!all_al) state_n = RX_RST;
      FAIL:      state_n = FAIL;
      default:   state_n = IDLE;
    endcase
    if (tmo_hit) state_n = !can_retry ? FAIL : (state == RX_WAIT || state == ALIGN) ? RX_RST : WAIT_QPLL;
    if (!i_enable) state_n = IDLE;
  end
  assign retry_inc = tmo_hit && can_retry && i_enable;
  assign retry_clr = (state == IDLE || state == UP) && state_n != state;
  // a WAIT_QPLL retry re-enters the same state, so it must restart the timer explicitly
  assign restart = state_n != state || retry_inc;
  always_ff @(posedge i_sysclk) begin
    if (!i_rst_n) begin
      state <= IDLE;
      qpll_sy <= '0;
      tx_sy <= '0;
      rx_sy <= '0;
      al_sy <= '0;
      tmo_cnt <= '0;
      stb_cnt <= '0;
      retry_cnt <= '0;
    end else begin
      state <= state_n;
      qpll_sy <= {qpll_sy[0], i_qplllock};
      tx_sy <= {tx_sy[0], i_tx_done};
      rx_sy <= {rx_sy[0], i_rx_done};
      al_sy <= {al_sy[0], i_rx_ByteAlign};
      tmo_cnt <= restart ? '0 : tmo_cnt + {31'd0, ~&tmo_cnt};
      stb_cnt <= (restart || state != ALIGN || !all_al) ? '0 : stb_cnt + SW'(1);
      retry_cnt <= retry_clr ? '0 : retry_cnt + 4'(retry_inc);
    end
  end
`ifdef GT_LINK_POL_AUTO_EN
  logic [NUM_CH-1:0] pol;
  always_ff @(posedge i_sysclk) begin
    if (!i_rst_n) pol <= RX_POL_INIT;
    else if (state == ALIGN && state_n == RX_RST) pol <= pol ^ ~al_sy[1];
  end
  assign o_rx_polarity = pol;
`else
  assign o_rx_polarity = RX_POL_INIT;
`endif
  assign o_tx_rst = {NUM_CH{state == IDLE || state == TX_RST || state == FAIL}};
  assign o_rx_rst = {NUM_CH{state == IDLE || state == RX_RST || state == FAIL}};
  assign o_ch_up = al_sy[1] & {NUM_CH{state == ALIGN || state == UP}};
  assign o_link_up = state == UP;
  assign o_fail = state == FAIL;
  assign o_retry_cnt = retry_cnt;
  assign o_state = state;
endmodule

// File: tb/tb_gt_link_ctrl.sv
// tb_gt_link_ctrl: directed bring-up steps with randomized delays/fault masks, checked against an
// attempt-level model of retries and polarity flips (model follows GT_LINK_POL_AUTO_EN like the DUT).
`timescale 1ns/1ps
module tb_gt_link_ctrl;
  localparam int N = 4, HOLD = 16, TMO = 1000, STB = 64, MR = 3;
`ifdef GT_LINK_POL_AUTO_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, qpll = 1'b0;
  logic [N-1:0] tx_done = '0, rx_done = '0, align_raw = '0, stuck = '0, flip = '0;
  logic [N-1:0] align, tx_rst, rx_rst, pol, ch_up;
  logic link_up, fail;
  logic [3:0] retry, st;
  logic [N-1:0] mpol [0:15];
  int checks = 0, errors = 0;
  // lanes listed in flip only align when their polarity bit is set
  assign align = align_raw & ~stuck & (~flip | pol);
  always #5 clk = ~clk;
  gt_link_ctrl #(.NUM_CH(N), .RST_HOLD_CYC(HOLD), .TIMEOUT_CYC(TMO), .STABLE_CYC(STB), .MAX_RETRY(MR)) dut (
    .i_sysclk(clk), .i_rst_n(rst_n), .i_enable(en), .i_qplllock(qpll), .i_tx_done(tx_done),
    .i_rx_done(rx_done), .i_rx_ByteAlign(align), .o_tx_rst(tx_rst), .o_rx_rst(rx_rst),
    .o_rx_polarity(pol), .o_ch_up(ch_up), .o_link_up(link_up), .o_fail(fail),
    .o_retry_cnt(retry), .o_state(st)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic do_reset;
    rst_n = 1'b0;
    en = 1'b0;
    tick;
    tick;
    rst_n = 1'b1;
    stuck = '0;
    flip = '0;
  endtask
  task automatic wait_st(input logic [3:0] s, input int lim);
    for (int b = 0; b < lim && st !== s; b++) tick;
  endtask
  task automatic pulse_len(input bit rx, output int n, output bit tx_seen);
    n = 0;
    tx_seen = 1'b0;
    for (int b = 0; b < 3000 && (rx ? rx_rst : tx_rst) !== '1; b++) tick;
    while ((rx ? rx_rst : tx_rst) === '1 && n < 3000) begin
      tx_seen |= |tx_rst;
      tick;
      n++;
    end
  endtask
  task automatic predict(input logic [N-1:0] s, input logic [N-1:0] f, output bit efail,
                         output int eretry, output logic [N-1:0] epol);
    logic [N-1:0] p, ok;
    bit done;
    p = '0;
    efail = 1'b1;
    eretry = MR;
    done = 1'b0;
    mpol[0] = p;
    for (int k = 0; k <= MR; k++) begin
      ok = ~s & (~f | p);
      if (!done && &ok) begin
        efail = 1'b0;
        eretry = k;
        done = 1'b1;
      end
      if (!done && k < MR) begin
        if (AUTO) p ^= ~ok;
        mpol[k+1] = p;
      end
    end
    epol = p;
  endtask
  task automatic run_trial(input logic [N-1:0] s, input logic [N-1:0] f, input string tag);
    bit ef;
    int er, last, b;
    logic [N-1:0] ep;
    predict(s, f, ef, er, ep);
    do_reset;
    stuck = s;
    flip = f;
    qpll = 1'b1;
    tx_done = '1;
    rx_done = '1;
    align_raw = '1;
    en = 1'b1;
    last = 0;
    b = 0;
    while (!link_up && !fail && b < 8000) begin
      tick;
      b++;
      if (32'(retry) != last) begin
        chk({tag, "_retry_step"}, 32'(retry), last + 1);
        last = int'(retry);
        chk({tag, "_pol_at_retry"}, 32'(pol), 32'(mpol[last]));
      end
    end
    chk({tag, "_fail"}, 32'(fail), 32'(ef));
    chk({tag, "_retry"}, 32'(retry), er);
    chk({tag, "_state"}, 32'(st), ef ? 8 : 7);
    chk({tag, "_pol"}, 32'(pol), 32'(ep));
  endtask
  initial begin
    int n;
    bit txs;
    logic [N-1:0] rs, rf;
    tick;
    tick;
    chk("rst_state", 32'(st), 0);
    chk("rst_tx_rst", 32'(tx_rst), 4'hF);
    chk("rst_rx_rst", 32'(rx_rst), 4'hF);
    chk("rst_pol", 32'(pol), 0);
    chk("rst_link_fail", {30'd0, link_up, fail}, 0);
    chk("rst_ch_up", 32'(ch_up), 0);
    chk("rst_retry", 32'(retry), 0);
    rst_n = 1'b1;
    tick;
    chk("idle_hold", 32'(st), 0);
    en = 1'b1;
    tick;
    chk("nom_wait_qpll", 32'(st), 1);
    repeat ($urandom_range(1, 20)) tick;
    qpll = 1'b1;
    pulse_len(1'b0, n, txs);
    chk("nom_tx_pulse", n, HOLD);
    chk("nom_tx_wait", 32'(st), 3);
    repeat ($urandom_range(1, 20)) tick;
    tx_done = '1;
    pulse_len(1'b1, n, txs);
    chk("nom_rx_pulse", n, HOLD);
    chk("nom_tx_quiet", 32'(txs), 0);
    chk("nom_rx_wait", 32'(st), 5);
    chk("nom_ch_up_off", 32'(ch_up), 0);
    repeat ($urandom_range(1, 20)) tick;
    rx_done = '1;
    wait_st(4'd6, 100);
    chk("nom_align_state", 32'(st), 6);
    align_raw = 4'b1011;
    repeat (4) tick;
    chk("nom_ch_up_partial", 32'(ch_up), 4'b1011);
    align_raw = '1;
    n = 0;
    do begin
      tick;
      n++;
    end while (!link_up && n < 300);
    chk("nom_up_latency", n, STB + 2);
    chk("nom_retry", 32'(retry), 0);
    chk("nom_ch_up_all", 32'(ch_up), 4'hF);
    align_raw[0] = 1'b0;
    n = 0;
    do begin
      tick;
      n++;
      if (n == 1) align_raw[0] = 1'b1;
    end while (link_up && n < 20);
    chk("up_drop_latency", n, 3);
    chk("up_drop_state", 32'(st), 4);
    pulse_len(1'b1, n, txs);
    chk("up_rx_pulse", n, HOLD);
    for (int b = 0; b < 300 && !link_up; b++) tick;
    chk("up_recover", 32'(link_up), 1);
    chk("up_retry", 32'(retry), 0);
    do_reset;
    qpll = 1'b0;
    en = 1'b1;
    n = 0;
    do begin
      tick;
      n++;
    end while (retry == 4'd0 && n < 3000);
    chk("qpll_timeout_cyc", n, TMO + 1);
    chk("qpll_retry_state", 32'(st), 1);
    do_reset;
    qpll = 1'b1;
    rx_done = '0;
    en = 1'b1;
    wait_st(4'd5, 100);
    chk("dis_rx_wait", 32'(st), 5);
    en = 1'b0;
    tick;
    chk("dis_state", 32'(st), 0);
    chk("dis_resets", {tx_rst, rx_rst}, 8'hFF);
    chk("dis_link", {30'd0, link_up, fail}, 0);
    rx_done = '1;
    align_raw = 4'b0111;
    en = 1'b1;
    wait_st(4'd6, 100);
    repeat (3) tick;
    chk("rst_align_ch_up", 32'(ch_up), 4'b0111);
    rst_n = 1'b0;
    tick;
    chk("rst_align_state", 32'(st), 0);
    chk("rst_align_resets", {tx_rst, rx_rst}, 8'hFF);
    chk("rst_align_outs", {pol, ch_up, retry, 2'b00, link_up, fail}, 0);
    rst_n = 1'b1;
    run_trial(4'b0100, 4'b0000, "stuck2");
    run_trial(4'b0000, 4'b0010, "polrec");
    for (int t = 0; t < 3; t++) begin
      rs = ($urandom_range(0, 2) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'b0000;
      rf = 4'($urandom_range(0, 15));
      run_trial(rs, rf, $sformatf("rnd%0d", t));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/gt_link_ctrl.md
GT_LINK_CTRL -- requirements
Module: gt_link_ctrl

Interface
REQ-001 SHALL have parameters, one per line:
- NUM_CH, 4, channel count (1..8)
- RST_HOLD_CYC, 16, reset pulse width in cycles
- TIMEOUT_CYC, 1000000, per-phase timeout in cycles
- STABLE_CYC, 1024, cycles all-aligned before link declared up
- MAX_RETRY, 3, retries before FAIL
- RX_POL_INIT, {NUM_CH{1'b0}}, initial RX polarity vector
REQ-002 SHALL have ports (name direction width meaning), one per line:
- i_sysclk in 1 sole clock; all logic on rising edge
- i_rst_n in 1 synchronous active-low reset
- i_enable in 1 bring-up request, level
- i_qplllock in 1 shared QPLL lock
- i_tx_done in NUM_CH per-channel TX reset-FSM done
- i_rx_done in NUM_CH per-channel RX reset done
- i_rx_ByteAlign in NUM_CH per-channel comma alignment
- o_tx_rst out NUM_CH per-channel TX reset, active-high
- o_rx_rst out NUM_CH per-channel RX reset, active-high
- o_rx_polarity out NUM_CH per-channel RX polarity
- o_ch_up out NUM_CH per-channel aligned, synchronised
- o_link_up out 1 all channels up and stable
- o_fail out 1 retries exhausted
- o_retry_cnt out 4 retries used in current bring-up
- o_state out 4 FSM state code
REQ-003 SHALL use one clock and a synchronous active-low reset: i_sysclk, i_rst_n.

Function
REQ-004 SHALL pass i_qplllock, i_tx_done, i_rx_done and i_rx_ByteAlign through 2-flop synchronisers; all decisions use synchronised values (2-cycle input latency).
REQ-005 SHALL use state codes IDLE=0, WAIT_QPLL=1, TX_RST=2, TX_WAIT=3, RX_RST=4, RX_WAIT=5, ALIGN=6, UP=7, FAIL=8.
REQ-006 IDLE: o_tx_rst and o_rx_rst all 1; i_enable=1 -> WAIT_QPLL with o_retry_cnt cleared to 0.
REQ-007 WAIT_QPLL: qplllock=1 -> TX_RST; timeout -> retry (REQ-013).
REQ-008 TX_RST: o_tx_rst all 1 for exactly RST_HOLD_CYC cycles, then -> TX_WAIT with o_tx_rst deasserted.
REQ-009 TX_WAIT: &tx_done -> RX_RST; timeout -> retry.
REQ-010 RX_RST: o_rx_rst all 1 for RST_HOLD_CYC cycles; o_tx_rst stays 0; then -> RX_WAIT.
REQ-011 RX_WAIT: &rx_done -> ALIGN; timeout -> retry.
REQ-012 ALIGN: stable counter increments while &ByteAlign; any bit low clears it; count reaching STABLE_CYC -> UP; timeout -> retry.
REQ-013 Retry: if o_retry_cnt < MAX_RETRY, increment it and go to WAIT_QPLL (ALIGN/RX_WAIT timeouts go to RX_RST instead); otherwise go to FAIL.
REQ-014 UP: o_link_up=1; any synchronised ByteAlign or qplllock low -> o_link_up=0 the next cycle and enter RX_RST (WAIT_QPLL on qplllock loss), with o_retry_cnt cleared.
REQ-015 FAIL: o_fail=1 and all resets asserted; held until i_enable deasserts.
REQ-016 i_enable=0 in any state -> IDLE the next cycle; this overrides every other transition.
REQ-017 Timeout counter: 32-bit; cleared on every state entry; timeout fires when count == TIMEOUT_CYC-1; no wrap.
REQ-018 o_ch_up = synchronised ByteAlign ANDed with (state==ALIGN or UP); otherwise 0.

Reset
REQ-019 While i_rst_n=0 at a clock edge, the block SHALL take:
- state IDLE
- o_tx_rst and o_rx_rst all 1
- o_rx_polarity = RX_POL_INIT
- o_link_up, o_fail, o_ch_up 0
- o_retry_cnt 0
- all counters and synchronisers 0
REQ-020 Reset asserted mid-sequence SHALL abort it with no partial-state retention.

Configuration
REQ-021 Macro GT_LINK_POL_AUTO_EN defined: on each ALIGN timeout, each channel whose synchronised ByteAlign=0 SHALL toggle its o_rx_polarity bit, in the same cycle RX_RST is entered; aligned channels keep their polarity.
REQ-022 Macro GT_LINK_POL_AUTO_EN undefined: o_rx_polarity SHALL remain RX_POL_INIT at all times, with no toggle logic.

Verification (NUM_CH=4, RST_HOLD_CYC=16, TIMEOUT_CYC=1000, STABLE_CYC=64, MAX_RETRY=3)
REQ-023 The bench SHALL cover the following directed scenarios:
- Nominal: enable, then qplllock, tx_done=F, rx_done=F, align=F -> tx_rst pulse of 16 cycles, rx_rst pulse of 16 cycles, o_link_up=1 exactly 64+2 cycles after align; retry_cnt=0.
- Align bit 2 stuck 0: retry_cnt steps 1,2,3, then o_fail=1 and o_state=8. With GT_LINK_POL_AUTO_EN, o_rx_polarity=4'b0100 after the 1st retry and 4'b0000 after the 2nd.
- Polarity recovery (macro on): bit 1 aligns only when polarity[1]=1 -> link_up after retry 1; retry_cnt=1.
- In UP, drop align[0] for 1 cycle -> o_link_up=0 after 3 cycles, o_rx_rst pulsed, link recovers, retry_cnt=0.
- Deassert i_enable during RX_WAIT, and separately assert i_rst_n=0 in ALIGN -> IDLE next cycle, all resets 1, outputs at reset values.
